divx_multi: RTL and testbench

DIVX_MULTI -- requirements
Module: divx_multi

---
 rtl/divx_pkg.sv | 21 ++
 rtl/divx_chan.sv | 112 +++++++++++
 rtl/divx_multi.sv | 85 ++++++++
 tb/tb_divx_multi.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/divx_pkg.sv
// ==========================================================
// Package : divx_pkg
// Purpose : shared types and constants for the divx_multi divider
// Revision: 1.0
// ==========================================================
`default_nettype none

package divx_pkg;

  typedef enum logic [0:0] {
    OFF = 1'b0,
    RUN = 1'b1
  } divx_state_t;

  localparam int DIV_RST  = 2;
  localparam int HIGH_RST = 1;
  localparam int NCH_MAX  = 16;

endpackage

`default_nettype wire

// File: rtl/divx_chan.sv
// ==========================================================
// Module  : divx_chan
// Purpose : one divider channel - counter, run state, shadow config, clamp
// Revision: 1.0
// ==========================================================
`default_nettype none

module divx_chan
  import divx_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         i_en,
  input  logic         i_wr,
  input  logic [W-1:0] i_div,
  input  logic [W-1:0] i_high,
  input  logic         i_sync,
  output logic         o_clk,
  output logic         o_tick,
  output logic         o_pend
);

  divx_state_t r_state, w_state_n;
  logic [W-1:0] r_cnt, w_cnt_n;
  logic [W-1:0] r_div, w_div_n, r_high, w_high_n;
  logic [W-1:0] r_sdiv, w_sdiv_n, r_shigh, w_shigh_n;
  logic         r_pend, w_pend_n;
  logic         r_clk, w_clk_n;
  logic         r_tick, w_tick_n;
  logic         w_bound;
  logic         w_apply;
  logic [W-1:0] w_high_clamp;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= OFF;
      r_cnt   <= '0;
      r_div   <= W'(DIV_RST);
      r_high  <= W'(HIGH_RST);
      r_sdiv  <= W'(DIV_RST);
      r_shigh <= W'(HIGH_RST);
      r_pend  <= 1'b0;
      r_clk   <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_div   <= w_div_n;
      r_high  <= w_high_n;
      r_sdiv  <= w_sdiv_n;
      r_shigh <= w_shigh_n;
      r_pend  <= w_pend_n;
      r_clk   <= w_clk_n;
      r_tick  <= w_tick_n;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_cnt_n      = '0;
    w_div_n      = r_div;
    w_high_n     = r_high;
    w_sdiv_n     = r_sdiv;
    w_shigh_n    = r_shigh;
    w_pend_n     = r_pend;
    w_clk_n      = 1'b0;
    w_tick_n     = 1'b0;
    w_bound      = 1'b0;
    // Clamp once at write time so the active pair is always consistent
    w_high_clamp = (i_high >= i_div) ? (i_div - W'(1)) : i_high;

    case (r_state)
      OFF: begin
        w_bound = 1'b1;
        if (i_en) w_state_n = RUN;
      end
      RUN: begin
        if (!i_en) w_state_n = OFF;
        else       w_bound   = r_tick | i_sync;
      end
      default: w_state_n = OFF;
    endcase

    // A write landing on a boundary defers the whole shadow to the next one
    w_apply = w_bound & r_pend & ~i_wr;
    if (w_apply) begin
      w_div_n  = r_sdiv;
      w_high_n = r_shigh;
      w_pend_n = 1'b0;
    end
    if (i_wr) begin
      w_sdiv_n  = i_div;
      w_shigh_n = w_high_clamp;
      w_pend_n  = 1'b1;
    end

    if (w_state_n == RUN) begin
      w_cnt_n  = (r_state == RUN && !w_bound) ? (r_cnt + W'(1)) : '0;
      w_clk_n  = (w_cnt_n < w_high_n);
      w_tick_n = (w_cnt_n == (w_div_n - W'(1)));
    end
  end

  assign o_clk  = r_clk;
  assign o_tick = r_tick;
  assign o_pend = r_pend;

endmodule

`default_nettype wire

// File: rtl/divx_multi.sv
// ==========================================================
// Module  : divx_multi
// Purpose : NCH independent clock dividers with shadowed config writes;
//           DIVX_MULTI_SYNC_EN adds a SYNC input that realigns all channels
// Revision: 1.0
// ==========================================================
`default_nettype none

module divx_multi
  import divx_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W   = 32
) (
  input  logic                                    CLK,
  input  logic                                    RST,
  input  logic [NCH-1:0]                          EN,
  input  logic                                    CFG_WR,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] CFG_CH,
  input  logic [W-1:0]                            CFG_DIV,
  input  logic [W-1:0]                            CFG_HIGH,
  output logic [NCH-1:0]                          CLKout,
  output logic [NCH-1:0]                          TICK,
  output logic [NCH-1:0]                          PEND,
  output logic                                    CFG_ERR
`ifdef DIVX_MULTI_SYNC_EN
  ,
  input  logic                                    SYNC
`endif
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic           w_ch_ok;
  logic           w_valid;
  logic           w_sync;
  logic [NCH-1:0] w_wr;
  logic           r_err;

`ifdef DIVX_MULTI_SYNC_EN
  assign w_sync = SYNC;
`else
  assign w_sync = 1'b0;
`endif

  // Channel index can exceed NCH-1 when NCH is not a power of two
  assign w_ch_ok = (32'(CFG_CH) < 32'(NCH));
  assign w_valid = CFG_WR & w_ch_ok & (CFG_DIV >= W'(2));

  always_ff @(posedge CLK) begin
    if (!RST) r_err <= 1'b0;
    else      r_err <= CFG_WR & ~w_valid;
  end

  assign CFG_ERR = r_err;

  if (NCH >= 1 && NCH <= NCH_MAX) begin : g_chans
    for (genvar i = 0; i < NCH; i++) begin : g_ch
      assign w_wr[i] = w_valid & (CFG_CH == CW'(i));

      divx_chan #(
        .W (W)
      ) u_chan (
        .CLK    (CLK),
        .RST    (RST),
        .i_en   (EN[i]),
        .i_wr   (w_wr[i]),
        .i_div  (CFG_DIV),
        .i_high (CFG_HIGH),
        .i_sync (w_sync),
        .o_clk  (CLKout[i]),
        .o_tick (TICK[i]),
        .o_pend (PEND[i])
      );
    end
  end else begin : g_bad_nch
    assign w_wr   = '0;
    assign CLKout = '0;
    assign TICK   = '0;
    assign PEND   = '0;
  end

endmodule

`default_nettype wire

// File: tb/tb_divx_multi.sv
// ==========================================================
// Module  : tb_divx_multi
// Purpose : directed self-checking bench for divx_multi (NCH=3, W=16)
// Revision: 1.0
// ==========================================================
`default_nettype none

module tb_divx_multi;

  localparam int NCH = 3;
  localparam int W   = 16;

  logic           CLK;
  logic           RST;
  logic [NCH-1:0] EN;
  logic           CFG_WR;
  logic [1:0]     CFG_CH;
  logic [W-1:0]   CFG_DIV;
  logic [W-1:0]   CFG_HIGH;
  logic [NCH-1:0] CLKout;
  logic [NCH-1:0] TICK;
  logic [NCH-1:0] PEND;
  logic           CFG_ERR;
`ifdef DIVX_MULTI_SYNC_EN
  logic           SYNC;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  divx_multi #(
    .NCH (NCH),
    .W   (W)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .EN       (EN),
    .CFG_WR   (CFG_WR),
    .CFG_CH   (CFG_CH),
    .CFG_DIV  (CFG_DIV),
    .CFG_HIGH (CFG_HIGH),
    .CLKout   (CLKout),
    .TICK     (TICK),
    .PEND     (PEND),
    .CFG_ERR  (CFG_ERR)
`ifdef DIVX_MULTI_SYNC_EN
    ,
    .SYNC     (SYNC)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_wr(input logic [1:0] ch, input int div, input int high);
    CFG_WR   = 1'b1;
    CFG_CH   = ch;
    CFG_DIV  = W'(div);
    CFG_HIGH = W'(high);
  endtask

  initial begin
    RST = 1'b0; EN = '0; CFG_WR = 1'b0; CFG_CH = '0; CFG_DIV = '0; CFG_HIGH = '0;
`ifdef DIVX_MULTI_SYNC_EN
    SYNC = 1'b0;
`endif
    step(); step();
    chk("rst_clk",  32'(CLKout), 0);
    chk("rst_tick", 32'(TICK), 0);
    chk("rst_pend", 32'(PEND), 0);
    chk("rst_err",  32'(CFG_ERR), 0);

    // Default divide-by-2 on channel 0
    RST = 1'b1; EN = 3'b001;
    step();
    for (int k = 0; k < 6; k++) begin
      chk("def_clk0",  32'(CLKout[0]), 32'(k % 2 == 0));
      chk("def_tick0", 32'(TICK[0]),   32'(k % 2 == 1));
      step();
    end

    // Channel 1: DIV=10 HIGH=3
    set_wr(2'd1, 10, 3);
    step();
    chk("wr1_pend", 32'(PEND[1]), 1);
    CFG_WR = 1'b0; EN = 3'b011;
    step();
    chk("en1_pend", 32'(PEND[1]), 0);
    for (int k = 0; k < 20; k++) begin
      chk("d10_clk1",  32'(CLKout[1]), 32'(k % 10 < 3));
      chk("d10_tick1", 32'(TICK[1]),   32'(k % 10 == 9));
      step();
    end

    // Mid-period write at cnt=5 waits for the boundary
    repeat (5) step();
    set_wr(2'd1, 4, 2);
    step();
    CFG_WR = 1'b0;
    for (int c = 6; c < 10; c++) begin
      chk("mid_pend1", 32'(PEND[1]), 1);
      chk("mid_tick1", 32'(TICK[1]), 32'(c == 9));
      step();
    end
    chk("mid_applied", 32'(PEND[1]), 0);
    for (int k = 0; k < 8; k++) begin
      chk("d4_clk1",  32'(CLKout[1]), 32'(k % 4 < 2));
      chk("d4_tick1", 32'(TICK[1]),   32'(k % 4 == 3));
      step();
    end

    // Write during the TICK cycle applies one period later
    repeat (3) step();
    chk("tw_tick1", 32'(TICK[1]), 1);
    set_wr(2'd1, 6, 1);
    step();
    CFG_WR = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("tw_pend1", 32'(PEND[1]), 1);
      chk("tw_clk1",  32'(CLKout[1]), 32'(c < 2));
      chk("tw_tick1", 32'(TICK[1]),   32'(c == 3));
      step();
    end
    chk("tw_applied", 32'(PEND[1]), 0);
    for (int k = 0; k < 6; k++) begin
      chk("d6_clk1",  32'(CLKout[1]), 32'(k == 0));
      chk("d6_tick1", 32'(TICK[1]),   32'(k == 5));
      step();
    end

    // Rejected writes
    set_wr(2'd2, 1, 0);
    step();
    CFG_WR = 1'b0;
    chk("err_div_pulse", 32'(CFG_ERR), 1);
    chk("err_div_pend",  32'(PEND), 0);
    step();
    chk("err_div_clear", 32'(CFG_ERR), 0);
    set_wr(2'd3, 5, 1);
    step();
    CFG_WR = 1'b0;
    chk("err_ch_pulse", 32'(CFG_ERR), 1);
    chk("err_ch_pend",  32'(PEND), 0);
    step();
    chk("err_ch_clear", 32'(CFG_ERR), 0);

    // HIGH >= DIV clamps to DIV-1
    set_wr(2'd2, 8, 12);
    step();
    CFG_WR = 1'b0;
    chk("clamp_err",  32'(CFG_ERR), 0);
    chk("clamp_pend", 32'(PEND), 32'b100);
    EN = 3'b111;
    step();
    for (int k = 0; k < 16; k++) begin
      chk("clamp_clk2",  32'(CLKout[2]), 32'(k % 8 < 7));
      chk("clamp_tick2", 32'(TICK[2]),   32'(k % 8 == 7));
      step();
    end

    // Reset mid-period with a pending write
    EN = 3'b101;
    step();
    chk("off_clk1",  32'(CLKout[1]), 0);
    chk("off_tick1", 32'(TICK[1]), 0);
    set_wr(2'd1, 10, 3);
    step();
    CFG_WR = 1'b0; EN = 3'b111;
    step();
    repeat (5) step();
    set_wr(2'd1, 4, 2);
    step();
    CFG_WR = 1'b0;
    chk("pre_rst_pend1", 32'(PEND[1]), 1);
    chk("pre_rst_clk1",  32'(CLKout[1]), 0);
    RST = 1'b0;
    step();
    chk("mrst_clk",  32'(CLKout), 0);
    chk("mrst_tick", 32'(TICK), 0);
    chk("mrst_pend", 32'(PEND), 0);
    chk("mrst_err",  32'(CFG_ERR), 0);
    RST = 1'b1;
    step();
    chk("restart_clk_a",  32'(CLKout), 32'b111);
    chk("restart_tick_a", 32'(TICK), 0);
    step();
    chk("restart_clk_b",  32'(CLKout), 0);
    chk("restart_tick_b", 32'(TICK), 32'b111);
    step();
    chk("restart_clk_c",  32'(CLKout), 32'b111);

`ifdef DIVX_MULTI_SYNC_EN
    set_wr(2'd0, 6, 3);
    step();
    set_wr(2'd1, 3, 1);
    step();
    CFG_WR = 1'b0;
    repeat (7) step();
    chk("sync_pre_pend", 32'(PEND), 0);
    SYNC = 1'b1;
    step();
    SYNC = 1'b0;
    for (int k = 0; k < 12; k++) begin
      chk("sync_clk0",  32'(CLKout[0]), 32'(k % 6 < 3));
      chk("sync_tick0", 32'(TICK[0]),   32'(k % 6 == 5));
      chk("sync_clk1",  32'(CLKout[1]), 32'(k % 3 == 0));
      chk("sync_tick1", 32'(TICK[1]),   32'(k % 3 == 2));
      step();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
